// File: rtl/usb_packet_framer.sv
// Buffers the controller's 16-bit word stream and frames it into HDR/SEQ/LEN/payload/TRL packets for the USB FIFO.
// Build option FRAMER_CHECKSUM_EN inserts an XOR checksum word between payload and trailer.
module usb_packet_framer #(
  parameter int          ADDR_W    = 9,
  parameter int          PKT_WORDS = 256,
  parameter logic [15:0] HEADER    = 16'hA5A5,
  parameter logic [15:0] TRAILER   = 16'h5A5A
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              UsbStartStop,
  input  logic [15:0]       InData,
  input  logic              InData_en,
  input  logic              UsbDataFifoFull,
  output logic [15:0]       UsbFifoData,
  output logic              UsbFifoData_en,
  output logic              DataTransmitDone,
  output logic              Overflow,
  output logic [ADDR_W:0]   BufferCount
);
  localparam int              DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PKT_L  = (ADDR_W+1)'(PKT_WORDS);
  localparam logic [ADDR_W:0] FULL_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L  = (ADDR_W+1)'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_SEQ  = 3'd2;
  localparam logic [2:0] S_LEN  = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_CKS  = 3'd5;
  localparam logic [2:0] S_TRL  = 3'd6;

  logic [15:0]     r_mem [DEPTH];
  logic [ADDR_W:0] r_wptr, r_rptr;
  logic [2:0]      r_state;
  logic [15:0]     r_seq;
  logic            r_seq_pend;
  logic [ADDR_W:0] r_len, r_pcnt;
  logic [15:0]     r_cks;
  logic            r_ss_d, r_ovf, r_arm, r_done;

  logic [ADDR_W:0] w_count;
  logic            w_full, w_wr, w_rd, w_rise, w_fall, w_adv, w_last;
  logic [15:0]     w_head, w_data;

  assign w_count = r_wptr - r_rptr;
  assign w_full  = (w_count == FULL_L);
  assign w_wr    = InData_en & ~w_full;
  assign w_rise  = UsbStartStop & ~r_ss_d;
  assign w_fall  = ~UsbStartStop & r_ss_d;
  // Every non-idle state emits exactly one word per unstalled cycle.
  assign w_adv   = (r_state != S_IDLE) & ~UsbDataFifoFull;
  assign w_rd    = w_adv & (r_state == S_PAY);
  assign w_head  = r_mem[r_rptr[ADDR_W-1:0]];
  assign w_last  = (r_pcnt == r_len - ONE_L);

  always_comb begin
    w_data = '0;
    case (r_state)
      S_HDR:   w_data = HEADER;
      S_SEQ:   w_data = r_seq;
      S_LEN:   w_data = 16'(r_len);
      S_PAY:   w_data = w_head;
      S_CKS:   w_data = r_cks;
      S_TRL:   w_data = TRAILER;
      default: w_data = '0;
    endcase
  end

  assign UsbFifoData      = w_data;
  assign UsbFifoData_en   = w_adv;
  assign DataTransmitDone = r_done;
  assign Overflow         = r_ovf;
  assign BufferCount      = w_count;

  always_ff @(posedge Clk)
    if (w_wr) r_mem[r_wptr[ADDR_W-1:0]] <= InData;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_state    <= S_IDLE;
      r_seq      <= '0;
      r_seq_pend <= 1'b0;
      r_len      <= '0;
      r_pcnt     <= '0;
      r_cks      <= '0;
      r_ss_d     <= 1'b0;
      r_ovf      <= 1'b0;
      r_arm      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ss_d <= UsbStartStop;
      if (w_wr) r_wptr <= r_wptr + ONE_L;
      if (w_rd) r_rptr <= r_rptr + ONE_L;

      if (InData_en & w_full) r_ovf <= 1'b1;
      else if (w_rise)        r_ovf <= 1'b0;

      r_done <= 1'b0;
      if (w_rise) r_arm <= 1'b0;
      else if (w_fall) r_arm <= 1'b1;
      else if (r_arm & ~UsbStartStop & (r_state == S_IDLE) & (w_count == '0)) begin
        r_done <= 1'b1;
        r_arm  <= 1'b0;
      end

      // A start seen mid-packet is deferred so the packet in flight keeps its number.
      if ((r_state == S_TRL) & w_adv) begin
        r_seq      <= (r_seq_pend | w_rise) ? 16'h0000 : r_seq + 16'h0001;
        r_seq_pend <= 1'b0;
      end else if (w_rise) begin
        if (r_state == S_IDLE) r_seq <= '0;
        else                   r_seq_pend <= 1'b1;
      end

      if (r_state == S_IDLE) begin
        r_pcnt <= '0;
        r_cks  <= '0;
        if (w_count >= PKT_L) begin
          r_len   <= PKT_L;
          r_state <= S_HDR;
        end else if (~UsbStartStop & (w_count != '0)) begin
          r_len   <= w_count;
          r_state <= S_HDR;
        end
      end else if (w_adv) begin
        case (r_state)
          S_HDR: r_state <= S_SEQ;
          S_SEQ: r_state <= S_LEN;
          S_LEN: r_state <= S_PAY;
          S_PAY: begin
            r_cks  <= r_cks ^ w_head;
            r_pcnt <= r_pcnt + ONE_L;
`ifdef FRAMER_CHECKSUM_EN
            if (w_last) r_state <= S_CKS;
`else
            if (w_last) r_state <= S_TRL;
`endif
          end
          S_CKS:   r_state <= S_TRL;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_packet_framer.sv
// Directed bench for usb_packet_framer with a 4-deep buffer and 4-word packets.
module tb_usb_packet_framer;
  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        UsbStartStop = 1'b0;
  logic [15:0] InData = '0;
  logic        InData_en = 1'b0;
  logic        UsbDataFifoFull = 1'b0;
  logic [15:0] UsbFifoData;
  logic        UsbFifoData_en;
  logic        DataTransmitDone;
  logic        Overflow;
  logic [2:0]  BufferCount;

  usb_packet_framer #(.ADDR_W(2), .PKT_WORDS(4)) dut (
    .Clk(Clk), .reset_n(reset_n), .UsbStartStop(UsbStartStop),
    .InData(InData), .InData_en(InData_en), .UsbDataFifoFull(UsbDataFifoFull),
    .UsbFifoData(UsbFifoData), .UsbFifoData_en(UsbFifoData_en),
    .DataTransmitDone(DataTransmitDone), .Overflow(Overflow), .BufferCount(BufferCount));

  always #5 Clk = ~Clk;

  int          cmp = 0, errs = 0, cyc = 0, done_cnt = 0;
  logic [15:0] wq[$];
  int          tq[$];
  logic [15:0] stim_q[$];
  logic [15:0] exp_q[$];

  always @(posedge Clk) cyc++;
  always @(negedge Clk) begin
    if (UsbFifoData_en) begin
      wq.push_back(UsbFifoData);
      tq.push_back(cyc);
    end
    if (DataTransmitDone) done_cnt++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic feed();
    for (int i = 0; i < stim_q.size(); i++) begin
      InData = stim_q[i];
      InData_en = 1'b1;
      tick(1);
    end
    InData_en = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (wq.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    tick(2);
    @(negedge Clk);
    cmp++; if (UsbFifoData_en !== 1'b0) begin errs++; $display("FAIL rst_en got %b want 0", UsbFifoData_en); end
    cmp++; if (UsbFifoData !== 16'h0) begin errs++; $display("FAIL rst_data got %h want 0000", UsbFifoData); end
    cmp++; if (DataTransmitDone !== 1'b0) begin errs++; $display("FAIL rst_done got %b want 0", DataTransmitDone); end
    cmp++; if (Overflow !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", Overflow); end
    cmp++; if (BufferCount !== 3'd0) begin errs++; $display("FAIL rst_count got %0d want 0", BufferCount); end
    @(posedge Clk); #1;
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_full_packet();
    bit ok;
    UsbStartStop = 1'b1;
    done_cnt = 0;
    wq.delete(); tq.delete();
    stim_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    exp_q  = '{16'hA5A5, 16'h0000, 16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h5A5A};
    feed();
    wait_writes(8, 40, ok);
    cmp++; if (!ok) begin errs++; $display("FAIL full_timeout got %0d words want 8", wq.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errs++; $display("FAIL full_word%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp_q[i]);
      end
    end
    cmp++; if (tq.size() < 8 || tq[7] - tq[0] != 7) begin errs++; $display("FAIL full_consecutive span got %0d want 7", (tq.size() >= 8) ? tq[7] - tq[0] : -1); end
    tick(4);
    cmp++; if (done_cnt != 0) begin errs++; $display("FAIL full_no_done got %0d want 0", done_cnt); end
  endtask

  task automatic test_multi_packet();
    bit ok;
    for (int p = 0; p < 2; p++) begin
      wq.delete();
      stim_q = '{16'h0010 + 16'(4*p), 16'h0011 + 16'(4*p), 16'h0012 + 16'(4*p), 16'h0013 + 16'(4*p)};
      exp_q  = '{16'hA5A5, 16'(p + 1), 16'h0004, stim_q[0], stim_q[1], stim_q[2], stim_q[3], 16'h5A5A};
      feed();
      wait_writes(8, 40, ok);
      cmp++; if (!ok) begin errs++; $display("FAIL multi%0d_timeout got %0d words want 8", p, wq.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        cmp++;
        if (i >= wq.size() || wq[i] !== exp_q[i]) begin
          errs++; $display("FAIL multi%0d_word%0d got %h want %h", p, i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_partial();
    bit ok;
    wq.delete();
    done_cnt = 0;
    stim_q = '{16'h0011, 16'h0022, 16'h0033};
    exp_q  = '{16'hA5A5, 16'h0003, 16'h0003, 16'h0011, 16'h0022, 16'h0033, 16'h5A5A};
    feed();
    tick(3);
    cmp++; if (wq.size() != 0) begin errs++; $display("FAIL partial_hold got %0d words want 0", wq.size()); end
    UsbStartStop = 1'b0;
    wait_writes(7, 40, ok);
    cmp++; if (!ok) begin errs++; $display("FAIL partial_timeout got %0d words want 7", wq.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errs++; $display("FAIL partial_word%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp_q[i]);
      end
    end
    tick(8);
    cmp++; if (done_cnt != 1) begin errs++; $display("FAIL partial_done got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_stall();
    bit ok;
    int bad = 0;
    UsbStartStop = 1'b1;
    wq.delete();
    stim_q = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    exp_q  = '{16'hA5A5, 16'h0000, 16'h0004, 16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h5A5A};
    feed();
    wait_writes(4, 40, ok);
    UsbDataFifoFull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (UsbFifoData_en !== 1'b0) bad++;
      @(posedge Clk); #1;
    end
    UsbDataFifoFull = 1'b0;
    cmp++; if (bad != 0) begin errs++; $display("FAIL stall_en got %0d strobes want 0", bad); end
    wait_writes(8, 40, ok);
    cmp++; if (!ok) begin errs++; $display("FAIL stall_timeout got %0d words want 8", wq.size()); end
    tick(4);
    cmp++; if (wq.size() != 8) begin errs++; $display("FAIL stall_count got %0d words want 8", wq.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errs++; $display("FAIL stall_word%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    wq.delete();
    UsbDataFifoFull = 1'b1;
    stim_q = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204, 16'h0205};
    exp_q  = '{16'hA5A5, 16'h0001, 16'h0004, 16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h5A5A};
    feed();
    @(negedge Clk);
    cmp++; if (BufferCount !== 3'd4) begin errs++; $display("FAIL ovf_count got %0d want 4", BufferCount); end
    cmp++; if (Overflow !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b want 1", Overflow); end
    cmp++; if (wq.size() != 0) begin errs++; $display("FAIL ovf_blocked got %0d words want 0", wq.size()); end
    @(posedge Clk); #1;
    UsbDataFifoFull = 1'b0;
    wait_writes(8, 40, ok);
    cmp++; if (!ok) begin errs++; $display("FAIL ovf_timeout got %0d words want 8", wq.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errs++; $display("FAIL ovf_word%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp_q[i]);
      end
    end
    done_cnt = 0;
    UsbStartStop = 1'b0;
    tick(5);
    cmp++; if (Overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky got %b want 1", Overflow); end
    cmp++; if (done_cnt != 1) begin errs++; $display("FAIL ovf_empty_done got %0d pulses want 1", done_cnt); end
    UsbStartStop = 1'b1;
    tick(2);
    @(negedge Clk);
    cmp++; if (Overflow !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", Overflow); end
    @(posedge Clk); #1;
  endtask

  task automatic test_checksum();
    bit ok;
    wq.delete();
    done_cnt = 0;
    stim_q = '{16'h0F0F, 16'h00FF};
`ifdef FRAMER_CHECKSUM_EN
    exp_q = '{16'hA5A5, 16'h0000, 16'h0002, 16'h0F0F, 16'h00FF, 16'h0FF0, 16'h5A5A};
`else
    exp_q = '{16'hA5A5, 16'h0000, 16'h0002, 16'h0F0F, 16'h00FF, 16'h5A5A};
`endif
    feed();
    UsbStartStop = 1'b0;
    wait_writes(exp_q.size(), 40, ok);
    cmp++; if (!ok) begin errs++; $display("FAIL cks_timeout got %0d words want %0d", wq.size(), exp_q.size()); end
    tick(6);
    cmp++; if (wq.size() != exp_q.size()) begin errs++; $display("FAIL cks_len got %0d words want %0d", wq.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp++;
      if (i >= wq.size() || wq[i] !== exp_q[i]) begin
        errs++; $display("FAIL cks_word%0d got %h want %h", i, (i < wq.size()) ? wq[i] : 16'hxxxx, exp_q[i]);
      end
    end
    cmp++; if (done_cnt != 1) begin errs++; $display("FAIL cks_done got %0d pulses want 1", done_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    int n;
    UsbStartStop = 1'b1;
    tick(2);
    wq.delete();
    stim_q = '{16'h0300, 16'h0301, 16'h0302, 16'h0303};
    feed();
    wait_writes(5, 40, ok);
    reset_n = 1'b0;
    @(negedge Clk);
    cmp++; if (UsbFifoData_en !== 1'b0) begin errs++; $display("FAIL mrst_en got %b want 0", UsbFifoData_en); end
    cmp++; if (BufferCount !== 3'd0) begin errs++; $display("FAIL mrst_count got %0d want 0", BufferCount); end
    n = wq.size();
    @(posedge Clk); #1;
    reset_n = 1'b1;
    tick(10);
    cmp++; if (wq.size() != n) begin errs++; $display("FAIL mrst_resume got %0d words want %0d", wq.size(), n); end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_multi_packet();
    test_partial();
    test_stall();
    test_overflow();
    test_checksum();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
